// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory arbiter.
// Optional misaligned-access checking in the arbiter is enabled by MEM_ARB_ALIGN_CHK_EN.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StRsp,
        StMrg,
        StWr
    } arb_state_t;

    typedef enum logic {
        ARB_IFU = 1'b0,
        ARB_LSU = 1'b1
    } arb_port_t;

    localparam logic [3:0] BE_FULL = 4'hF;
    localparam logic [3:0] BE_NONE = 4'h0;

    localparam int unsigned NUM_LANES = 4;

endpackage

// File: rtl/mem_arb_merge.sv
// Byte-lane merge for read-modify-write stores: lanes with be set take the new word,
// all other lanes keep the word read from memory.
module mem_arb_merge
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]    old_word_i,
    input  logic [DATA_W-1:0]    new_word_i,
    input  logic [NUM_LANES-1:0] be_i,
    output logic [DATA_W-1:0]    merged_o
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign merged_o[8*i +: 8] = be_i[i] ? new_word_i[8*i +: 8] : old_word_i[8*i +: 8];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between fetch and load/store,
// with read-modify-write for partial stores. Define MEM_ARB_ALIGN_CHK_EN for misalignment errors.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ifu_req,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_gnt,
    output logic              ifu_rvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [3:0]        lsu_be,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_gnt,
    output logic              lsu_rvalid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_read_data
);

    arb_state_t        state_q, state_d;
    arb_port_t         last_q, last_d;
    arb_port_t         port_q, port_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
    logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;

    logic              idle;
    logic              grant_ifu;
    logic              grant_lsu;
    arb_port_t         sel_port;
    logic [ADDR_W-1:0] sel_addr;
    logic              misalign;
    logic              lsu_rsp;
    logic [DATA_W-1:0] rsp_data;
    logic [DATA_W-1:0] merged;

`ifdef MEM_ARB_ALIGN_CHK_EN
    localparam bit AlignChkEn = 1'b1;
    assign lsu_err = lsu_rvalid & err_q;
`else
    localparam bit AlignChkEn = 1'b0;
    assign lsu_err = 1'b0;
`endif

    // last_q records the port granted most recently; on contention the other one wins.
    assign idle      = (state_q == StIdle);
    assign grant_ifu = idle && ifu_req && (!lsu_req || (last_q == ARB_LSU));
    assign grant_lsu = idle && lsu_req && (!ifu_req || (last_q == ARB_IFU));
    assign sel_port  = grant_lsu ? ARB_LSU : ARB_IFU;
    assign sel_addr  = grant_lsu ? lsu_addr : ifu_addr;
    assign misalign  = |sel_addr[1:0];

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        port_d  = port_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (grant_ifu || grant_lsu) begin
                    port_d  = sel_port;
                    last_d  = sel_port;
                    addr_d  = {sel_addr[ADDR_W-1:2], 2'b00};
                    we_d    = grant_lsu & lsu_we;
                    be_d    = lsu_be;
                    wdata_d = lsu_wdata;
                    err_d   = AlignChkEn & misalign;
                    if (err_d) begin
                        state_d = StRsp;
                    end else if (we_d && ((lsu_be == BE_FULL) || (lsu_be == BE_NONE))) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd:    state_d = we_q ? StMrg : StRsp;
            default: state_d = StIdle;
        endcase
    end

    mem_arb_merge #(
        .DATA_W(DATA_W)
    ) u_merge (
        .old_word_i(mem_read_data),
        .new_word_i(wdata_q),
        .be_i      (be_q),
        .merged_o  (merged)
    );

    // Errored responses never touch memory and return a zero word.
    assign rsp_data   = err_q ? '0 : mem_read_data;
    assign lsu_rsp    = (state_q == StRsp) && (port_q == ARB_LSU);
    assign ifu_rvalid = (state_q == StRsp) && (port_q == ARB_IFU);
    assign lsu_rvalid = lsu_rsp || (state_q == StWr) || (state_q == StMrg);
    assign ifu_gnt    = grant_ifu;
    assign lsu_gnt    = grant_lsu;

    assign ifu_rdata   = ifu_rvalid ? rsp_data : ifu_rdata_q;
    assign lsu_rdata   = lsu_rsp ? rsp_data : lsu_rdata_q;
    assign ifu_rdata_d = ifu_rdata;
    assign lsu_rdata_d = lsu_rdata;

    assign mem_address      = addr_q;
    assign mem_write_enable = ((state_q == StWr) && (be_q != BE_NONE)) || (state_q == StMrg);
    assign mem_write_data   = (state_q == StMrg) ? merged :
                              (state_q == StWr)  ? wdata_q : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            last_q      <= ARB_IFU;
            port_q      <= ARB_IFU;
            addr_q      <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            ifu_rdata_q <= '0;
            lsu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            port_q      <= port_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a 64-word memory model plus a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ifu_req = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        ifu_gnt, ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic        lsu_req = 1'b0;
    logic        lsu_we = 1'b0;
    logic [3:0]  lsu_be = '0;
    logic [31:0] lsu_addr = '0;
    logic [31:0] lsu_wdata = '0;
    logic        lsu_gnt, lsu_rvalid, lsu_err;
    logic [31:0] lsu_rdata;
    logic [31:0] mem_address, mem_write_data;
    logic        mem_write_enable;
    logic [31:0] mem_read_data = '0;

    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    logic        tb_wr_en = 1'b0;
    logic [5:0]  tb_wr_idx = '0;
    logic [31:0] tb_wr_data = '0;

    int          wr_cnt = 0;
    logic [31:0] wr_data = '0;
    int          n_checks = 0;
    int          n_fail = 0;

    mem_arbiter #(
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ifu_req         (ifu_req),
        .ifu_addr        (ifu_addr),
        .ifu_gnt         (ifu_gnt),
        .ifu_rvalid      (ifu_rvalid),
        .ifu_rdata       (ifu_rdata),
        .lsu_req         (lsu_req),
        .lsu_we          (lsu_we),
        .lsu_be          (lsu_be),
        .lsu_addr        (lsu_addr),
        .lsu_wdata       (lsu_wdata),
        .lsu_gnt         (lsu_gnt),
        .lsu_rvalid      (lsu_rvalid),
        .lsu_rdata       (lsu_rdata),
        .lsu_err         (lsu_err),
        .mem_address     (mem_address),
        .mem_write_data  (mem_write_data),
        .mem_write_enable(mem_write_enable),
        .mem_read_data   (mem_read_data)
    );

    always #5 clk = ~clk;

    // Single-port memory with one-cycle registered read.
    always @(posedge clk) begin
        if (tb_wr_en) mem[tb_wr_idx] <= tb_wr_data;
        else if (mem_write_enable) mem[mem_address[7:2]] <= mem_write_data;
        mem_read_data <= mem[mem_address[7:2]];
    end

    always @(negedge clk) begin
        if (mem_write_enable) begin
            wr_cnt  <= wr_cnt + 1;
            wr_data <= mem_write_data;
        end
    end

    task automatic poke(input logic [5:0] idx, input logic [31:0] d);
        @(negedge clk);
        tb_wr_en = 1'b1; tb_wr_idx = idx; tb_wr_data = d; ref_mem[idx] = d;
        @(negedge clk);
        tb_wr_en = 1'b0;
    endtask

    // Drives one request and observes four cycles after the grant edge (lat = first rvalid cycle).
    task automatic run_txn(input bit p, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output bit granted, output int lat, output int n_rv,
                           output logic [31:0] rdata, output logic err, output int n_wr,
                           output logic [31:0] wdat);
        int w0;
        @(negedge clk);
        w0 = wr_cnt;
        if (p) begin
            lsu_req = 1'b1; lsu_we = we; lsu_be = be; lsu_addr = addr; lsu_wdata = wd;
        end else begin
            ifu_req = 1'b1; ifu_addr = addr;
        end
        granted = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (p ? lsu_gnt : ifu_gnt) begin
                granted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
        lat = 0; n_rv = 0; rdata = '0; err = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin ifu_req = 1'b0; lsu_req = 1'b0; end
            if (p ? lsu_rvalid : ifu_rvalid) begin
                n_rv++;
                if (lat == 0) begin
                    lat = c; rdata = p ? lsu_rdata : ifu_rdata; err = lsu_err;
                end
            end
        end
        #1;
        n_wr = wr_cnt - w0;
        wdat = wr_data;
    endtask

    task automatic test_reset();
        logic [31:0] rnd;
        for (int i = 0; i < 64; i++) begin
            rnd = $urandom;
            poke(i[5:0], rnd);
        end
        #1;
        n_checks++;
        if ({ifu_gnt, ifu_rvalid, ifu_rdata, lsu_gnt, lsu_rvalid, lsu_rdata, lsu_err,
             mem_address, mem_write_data, mem_write_enable} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got wen=%b addr=%h wdata=%h rv=%b/%b", mem_write_enable,
                     mem_address, mem_write_data, ifu_rvalid, lsu_rvalid);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_fetch();
        bit g; int lat, nrv, nwr; logic [31:0] rd, wdv; logic er;
        poke(6'd2, 32'hDEADBEEF);
        run_txn(1'b0, 1'b0, 4'h0, 32'h08, 32'h0, g, lat, nrv, rd, er, nwr, wdv);
        n_checks++;
        if (!g || lat != 2 || nrv != 1) begin
            n_fail++;
            $display("FAIL fetch_timing: got gnt=%b lat=%0d pulses=%0d expected 1 2 1", g, lat, nrv);
        end
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL fetch_data: got %h expected deadbeef", rd);
        end
    endtask

    task automatic test_full_store();
        bit g; int lat, nrv, nwr; logic [31:0] rd, wdv; logic er;
        run_txn(1'b1, 1'b1, 4'hF, 32'h10, 32'h11223344, g, lat, nrv, rd, er, nwr, wdv);
        ref_mem[4] = 32'h11223344;
        n_checks++;
        if (!g || lat != 1 || nrv != 1 || nwr != 1 || wdv !== 32'h11223344) begin
            n_fail++;
            $display("FAIL full_store: got gnt=%b lat=%0d pulses=%0d writes=%0d data=%h", g, lat,
                     nrv, nwr, wdv);
        end
        run_txn(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, g, lat, nrv, rd, er, nwr, wdv);
        n_checks++;
        if (lat != 2 || rd !== 32'h11223344 || nwr != 0) begin
            n_fail++;
            $display("FAIL load_after_store: got lat=%0d data=%h expected 2 11223344", lat, rd);
        end
    endtask

    task automatic test_rmw();
        bit g; int lat, nrv, nwr; logic [31:0] rd, wdv; logic er;
        poke(6'd4, 32'hAABBCCDD);
        run_txn(1'b1, 1'b1, 4'b0010, 32'h10, 32'h00001200, g, lat, nrv, rd, er, nwr, wdv);
        ref_mem[4] = 32'hAABB12DD;
        n_checks++;
        if (lat != 2 || nrv != 1 || nwr != 1 || wdv !== 32'hAABB12DD) begin
            n_fail++;
            $display("FAIL rmw_store: got lat=%0d writes=%0d data=%h expected 2 1 aabb12dd", lat,
                     nwr, wdv);
        end
        run_txn(1'b1, 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, g, lat, nrv, rd, er, nwr, wdv);
        n_checks++;
        if (lat != 1 || nrv != 1 || nwr != 0 || mem[4] !== 32'hAABB12DD) begin
            n_fail++;
            $display("FAIL be_none_store: got lat=%0d writes=%0d mem=%h expected 1 0 aabb12dd",
                     lat, nwr, mem[4]);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] old;
        old = mem[8];
        @(negedge clk);
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_be = 4'b0100; lsu_addr = 32'h20;
        lsu_wdata = 32'h00550000;
        @(posedge clk);
        @(negedge clk);
        lsu_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_write_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_precondition: got wen=%b expected 1 in merge cycle",
                     mem_write_enable);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (mem_write_enable !== 1'b0 || lsu_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_async: got wen=%b rvalid=%b expected 0 0", mem_write_enable,
                     lsu_rvalid);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (mem[8] !== old) begin
            n_fail++;
            $display("FAIL abort_nowrite: got %h expected %h", mem[8], old);
        end
        reset_n = 1'b1;
        ifu_req = 1'b1;
        #1;
        n_checks++;
        if (ifu_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_idle: got ifu_gnt=%b expected 1", ifu_gnt);
        end
        ifu_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit last_lsu; bit exp_lsu; int grants; int last_cyc;
        last_lsu = 1'b0;
        grants = 0; last_cyc = -1;
        @(negedge clk);
        ifu_req = 1'b1; ifu_addr = 32'h04; lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h0C;
        for (int cyc = 0; cyc < 60 && grants < 6; cyc++) begin
            #1;
            if (ifu_gnt && lsu_gnt) begin
                n_checks++; n_fail++;
                $display("FAIL rr_double_grant: both grants at cycle %0d", cyc);
            end else if (ifu_gnt || lsu_gnt) begin
                exp_lsu = !last_lsu;
                n_checks++;
                if (lsu_gnt !== exp_lsu) begin
                    n_fail++;
                    $display("FAIL rr_order: grant %0d got lsu=%b expected lsu=%b", grants,
                             lsu_gnt, exp_lsu);
                end
                if (last_cyc >= 0) begin
                    n_checks++;
                    if (cyc - last_cyc != 3) begin
                        n_fail++;
                        $display("FAIL rr_spacing: got %0d cycles expected 3", cyc - last_cyc);
                    end
                end
                last_lsu = lsu_gnt; last_cyc = cyc; grants++;
            end
            @(negedge clk);
        end
        ifu_req = 1'b0; lsu_req = 1'b0;
        n_checks++;
        if (grants != 6) begin
            n_fail++;
            $display("FAIL rr_timeout: got %0d grants expected 6", grants);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random();
        bit g; int lat, nrv, nwr; logic [31:0] rd, wdv; logic er;
        bit p; logic we; logic [3:0] be; logic [31:0] addr, wd, exp_word;
        logic [5:0] idx; int e_lat, e_wr;
        for (int t = 0; t < 40; t++) begin
            p   = 1'($urandom_range(0, 1));
            we  = p & 1'($urandom_range(0, 1));
            be  = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            idx = 6'($urandom_range(0, 63));
            wd  = $urandom;
`ifdef MEM_ARB_ALIGN_CHK_EN
            addr = {24'h0, idx, 2'b00};
`else
            addr = {24'h0, idx, 2'($urandom_range(0, 3))};
`endif
            exp_word = ref_mem[idx];
            if (!we) begin
                e_lat = 2; e_wr = 0;
            end else if (be == 4'hF) begin
                e_lat = 1; e_wr = 1; exp_word = wd;
            end else if (be == 4'h0) begin
                e_lat = 1; e_wr = 0;
            end else begin
                e_lat = 2; e_wr = 1;
                for (int b = 0; b < 4; b++) if (be[b]) exp_word[8*b +: 8] = wd[8*b +: 8];
            end
            run_txn(p, we, be, addr, wd, g, lat, nrv, rd, er, nwr, wdv);
            n_checks++;
            if (!g || lat != e_lat || nrv != 1 || nwr != e_wr || er !== 1'b0) begin
                n_fail++;
                $display("FAIL rand_ctrl[%0d]: got gnt=%b lat=%0d pulses=%0d wr=%0d err=%b exp lat=%0d wr=%0d",
                         t, g, lat, nrv, nwr, er, e_lat, e_wr);
            end
            n_checks++;
            if (!we && rd !== exp_word) begin
                n_fail++;
                $display("FAIL rand_load[%0d]: got %h expected %h", t, rd, exp_word);
            end else if (we && mem[idx] !== exp_word) begin
                n_fail++;
                $display("FAIL rand_store[%0d]: got %h expected %h", t, mem[idx], exp_word);
            end
            ref_mem[idx] = exp_word;
        end
    endtask

`ifdef MEM_ARB_ALIGN_CHK_EN
    task automatic test_align();
        bit g; int lat, nrv, nwr; logic [31:0] rd, wdv; logic er;
        run_txn(1'b1, 1'b1, 4'hF, 32'h13, 32'hCAFEF00D, g, lat, nrv, rd, er, nwr, wdv);
        n_checks++;
        if (!g || lat != 1 || nrv != 1 || er !== 1'b1 || nwr != 0) begin
            n_fail++;
            $display("FAIL align_lsu: got gnt=%b lat=%0d err=%b writes=%0d expected 1 1 1 0", g,
                     lat, er, nwr);
        end
        run_txn(1'b0, 1'b0, 4'h0, 32'h09, 32'h0, g, lat, nrv, rd, er, nwr, wdv);
        n_checks++;
        if (lat != 1 || nrv != 1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL align_ifu: got lat=%0d data=%h expected 1 00000000", lat, rd);
        end
    endtask
`endif

    task automatic test_memory_image();
        int bad;
        bad = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL memory_image: got %0d differing words expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_full_store();
        test_rmw();
        test_reset_abort();
        test_back_to_back();
        test_random();
`ifdef MEM_ARB_ALIGN_CHK_EN
        test_align();
`endif
        test_memory_image();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
